seg_display_driver: RTL and testbench

Downstream display stage for the hourglass timer: accepts a binary value (the remaining-seconds count) over a valid/ready handshake, converts it to four BCD digits with a sequential shift-and-add-3 converter, and time-multiplexes the digits onto the 4-digit active-low seven-segment display. It applies optional leading-zero blanking and per-digit decimal points. It replaces inline digit-scan and BCD logic in the timer top level.

---
 rtl/seg_display_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 65 ++++++
 rtl/seg_display_driver.sv | 81 ++++++++
 tb/tb_seg_display_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared types, constants and the seven-segment decode for the display driver.
// Contents: converter FSM state enum, MAX_VALUE saturation limit, SEG_BLANK
// pattern, and bcd_to_seg (active-low {g,f,e,d,c,b,a} decode).
package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int         VALUE_W   = 14;
    localparam logic [13:0] MAX_VALUE = 14'd9999;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    // Active-low segment pattern; anything that is not a decimal digit is dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to 4-digit BCD converter with valid/ready input.
// Ports: clk, rst, value_in/value_valid/value_ready (input handshake),
//        bcd (16-bit result, valid while done), done (one-cycle strobe in DONE state).
// Latency: accept at edge k, 14 SHIFT edges, DONE at k+15; busy (not ready) 15 cycles.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    output logic [15:0] bcd,
    output logic        done
);
    import seg_display_pkg::*;

    conv_state_t state;
    logic [13:0] bin_q;
    logic [15:0] scratch_q;
    logic [15:0] scratch_adj;
    logic [3:0]  shift_cnt;

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int n = 0; n < 4; n++) begin
            if (scratch_q[n*4 +: 4] >= 4'd5)
                scratch_adj[n*4 +: 4] = scratch_q[n*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            shift_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        bin_q     <= (value_in > MAX_VALUE) ? MAX_VALUE : value_in;
                        scratch_q <= '0;
                        shift_cnt <= 4'd14;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {scratch, binary} shifted left as one 30-bit register.
                    scratch_q <= {scratch_adj[14:0], bin_q[13]};
                    bin_q     <= {bin_q[12:0], 1'b0};
                    shift_cnt <= shift_cnt - 4'd1;
                    if (shift_cnt == 4'd1)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign value_ready = (state == IDLE);
    assign done        = (state == DONE);
    assign bcd         = scratch_q;

endmodule

// File: rtl/seg_display_driver.sv
// 4-digit multiplexed seven-segment driver fed by a valid/ready binary value.
// Ports: clk, rst, value_in/value_valid/value_ready, dp_in (per-digit DP),
//        an/seg/dp (active-low registered display outputs).
// Latency: new value visible on seg at accept edge + 16; input stalls (ready low) 15 cycles.
module seg_display_driver #(
    parameter int SCAN_DIV = 250_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    import seg_display_pkg::*;

    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic [15:0]      conv_bcd;
    logic             conv_done;
    logic [15:0]      disp_bcd;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       nib;
    logic             upper_zero;
    logic             blank;

    bin2bcd_seq u_conv (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .bcd         (conv_bcd),
        .done        (conv_done)
    );

    // Digit i is a leading zero when it and every digit to its left are zero.
    always_comb begin
        nib = disp_bcd[{digit_idx, 2'b00} +: 4];
        case (digit_idx)
            2'd1:    upper_zero = (disp_bcd[15:4]  == 12'd0);
            2'd2:    upper_zero = (disp_bcd[15:8]  == 8'd0);
            2'd3:    upper_zero = (disp_bcd[15:12] == 4'd0);
            default: upper_zero = 1'b0;
        endcase
        blank = BLANK_LZ && upper_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd  <= '0;
            scan_cnt  <= '0;
            digit_idx <= '0;
            an        <= 4'hF;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            if (conv_done)
                disp_bcd <= conv_bcd;

            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            // Outputs use the pre-edge digit_idx and disp_bcd.
            an  <= ~(4'b0001 << digit_idx);
            seg <= blank ? SEG_BLANK : bcd_to_seg(nib);
            dp  <= ~dp_in[digit_idx];
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] value_in;
    logic        value_valid;
    logic [3:0]  dp_in;
    logic        value_ready, value_ready_nb;
    logic [3:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
        .value_ready(value_ready), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
    );

    seg_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
        .value_ready(value_ready_nb), .dp_in(dp_in), .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    // Waits (bounded) until digit d is the active anode and captures the outputs.
    task automatic wait_digit(input int d, output bit found,
                              output logic [6:0] s, output logic [6:0] s_nb, output logic p);
        logic [3:0] tgt;
        tgt   = ~(4'b0001 << d);
        found = 1'b0;
        s = 'x; s_nb = 'x; p = 1'bx;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === tgt) begin
                found = 1'b1;
                s     = seg;
                s_nb  = seg_nb;
                p     = dp;
            end
        end
    endtask

    // Offers one value and measures how many sampled cycles value_ready stays low.
    task automatic send_value(input logic [13:0] v, output int busy);
        @(negedge clk);
        value_in    = v;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        busy = 0;
        while (!value_ready && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        rst = 1'b1; value_valid = 1'b0; value_in = '0; dp_in = 4'b0000;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        checks++; if (value_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", value_ready); end
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp_an  = ~(4'b0001 << ((n - 1) / 4));
            exp_seg = (n <= 4) ? 7'b1000000 : 7'b1111111;
            checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an n=%0d got=%b exp=%b", n, an, exp_an); end
            checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg n=%0d got=%b exp=%b", n, seg, exp_seg); end
            if (n == 1) begin
                checks++; if (dp !== 1'b1) begin errors++; $display("FAIL first_dp got=%b exp=1", dp); end
            end
        end
    endtask

    task automatic test_bcd_1234;
        int busy; bit f; logic [6:0] s, snb; logic p;
        logic [6:0] exp [4];
        exp[0] = 7'b0011001; exp[1] = 7'b0110000; exp[2] = 7'b0100100; exp[3] = 7'b1111001;
        send_value(14'd1234, busy);
        checks++; if (busy != 15) begin errors++; $display("FAIL busy_1234 got=%0d exp=15", busy); end
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f, s, snb, p);
            checks++; if (!f || s !== exp[d]) begin errors++; $display("FAIL bcd_1234 d=%0d got=%b exp=%b", d, s, exp[d]); end
        end
    endtask

    task automatic test_blanking;
        int busy; bit f; logic [6:0] s, snb; logic p;
        send_value(14'd7, busy);
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f, s, snb, p);
            checks++;
            if (!f || s !== ((d == 0) ? 7'b1111000 : 7'b1111111)) begin
                errors++; $display("FAIL blank7_lz d=%0d got=%b", d, s);
            end
            checks++;
            if (!f || snb !== ((d == 0) ? 7'b1111000 : 7'b1000000)) begin
                errors++; $display("FAIL blank7_nolz d=%0d got=%b", d, snb);
            end
        end
        send_value(14'd0, busy);
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f, s, snb, p);
            checks++;
            if (!f || s !== ((d == 0) ? 7'b1000000 : 7'b1111111)) begin
                errors++; $display("FAIL blank0 d=%0d got=%b", d, s);
            end
        end
    endtask

    task automatic test_saturate;
        int busy; bit f; logic [6:0] s, snb; logic p;
        send_value(14'd12000, busy);
        checks++; if (busy != 15) begin errors++; $display("FAIL busy_sat got=%0d exp=15", busy); end
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f, s, snb, p);
            checks++; if (!f || s !== 7'b0010000) begin errors++; $display("FAIL saturate d=%0d got=%b exp=0010000", d, s); end
        end
    endtask

    task automatic test_back_to_back;
        int busy; bit f; logic [6:0] s, snb; logic p;
        logic [6:0] exp [4];
        exp[0] = 7'b0000010; exp[1] = 7'b0010010; exp[2] = 7'b1111111; exp[3] = 7'b1111111;
        send_value(14'd1234, busy);
        @(negedge clk);
        value_in = 14'd56; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        busy = 0;
        while (!value_ready && busy < 40) begin
            busy++;
            if (busy == 3) begin value_in = 14'd99; value_valid = 1'b1; end
            else value_valid = 1'b0;
            @(negedge clk);
        end
        value_valid = 1'b0;
        checks++; if (busy != 15) begin errors++; $display("FAIL busy_56 got=%0d exp=15", busy); end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f, s, snb, p);
            checks++; if (!f || s !== exp[d]) begin errors++; $display("FAIL ignore99 d=%0d got=%b exp=%b", d, s, exp[d]); end
        end
    endtask

    task automatic test_reset_abort;
        bit f; logic [6:0] s, snb; logic p;
        @(negedge clk);
        value_in = 14'd1234; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL abort_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL abort_seg got=%b exp=1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL abort_dp got=%b exp=1", dp); end
        checks++; if (value_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", value_ready); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        wait_digit(0, f, s, snb, p);
        checks++; if (!f || s !== 7'b1000000) begin errors++; $display("FAIL abort_d0 got=%b exp=1000000", s); end
        wait_digit(3, f, s, snb, p);
        checks++; if (!f || s !== 7'b1111111) begin errors++; $display("FAIL abort_d3 got=%b exp=1111111", s); end
    endtask

    task automatic test_dp;
        int zeros;
        logic exp_dp;
        @(negedge clk);
        dp_in = 4'b0100;
        @(negedge clk);
        zeros = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            exp_dp = (an === 4'b1011) ? 1'b0 : 1'b1;
            if (dp === 1'b0) zeros++;
            checks++; if (dp !== exp_dp) begin errors++; $display("FAIL dp n=%0d an=%b got=%b exp=%b", n, an, dp, exp_dp); end
        end
        checks++; if (zeros != 4) begin errors++; $display("FAIL dp_count got=%0d exp=4", zeros); end
        dp_in = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_bcd_1234;
        test_blanking;
        test_saturate;
        test_back_to_back;
        test_reset_abort;
        test_dp;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
